// File: rtl/somador_serial.sv
// Bit-serial N-bit adder: one full-adder cell plus a carry flop, LSB first, valid/ready on both sides.
// Optional signed-overflow output enabled by defining SOMADOR_SERIAL_OVF_EN.
module somador_serial #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         C_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] S,
    output logic         C_out,
`ifdef SOMADOR_SERIAL_OVF_EN
    output logic         overflow,
`endif
    output logic         ocupado
);

    localparam int unsigned CW = (N > 2) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        SOMANDO = 2'd1,
        PRONTO  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic [N-1:0]   soma_q, soma_d;
    logic [N-1:0]   s_q, s_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           carry_q, carry_d;
    logic           c_out_q, c_out_d;
    logic           soma_bit;
    logic           carry_nxt;
`ifdef SOMADOR_SERIAL_OVF_EN
    logic           ovf_q, ovf_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= OCIOSO;
            a_q     <= '0;
            b_q     <= '0;
            soma_q  <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
`ifdef SOMADOR_SERIAL_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            soma_q  <= soma_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            c_out_q <= c_out_d;
`ifdef SOMADOR_SERIAL_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Next-state logic; the partial sum lives in soma_q so S only changes when a result completes.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        soma_d    = soma_q;
        s_d       = s_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        c_out_d   = c_out_q;
`ifdef SOMADOR_SERIAL_OVF_EN
        ovf_d     = ovf_q;
`endif
        soma_bit  = a_q[0] ^ b_q[0] ^ carry_q;
        carry_nxt = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

        case (state_q)
            OCIOSO: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B;
                    carry_d = C_in;
                    soma_d  = '0;
                    cnt_d   = '0;
                    state_d = SOMANDO;
                end
            end
            SOMANDO: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = carry_nxt;
                soma_d  = {soma_bit, soma_q[N-1:1]};
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    s_d     = {soma_bit, soma_q[N-1:1]};
                    c_out_d = carry_nxt;
`ifdef SOMADOR_SERIAL_OVF_EN
                    ovf_d   = carry_q ^ carry_nxt;
`endif
                    cnt_d   = '0;
                    state_d = PRONTO;
                end
            end
            PRONTO: begin
                if (out_ready) begin
                    state_d = OCIOSO;
                end
            end
            default: state_d = OCIOSO;
        endcase
    end

    assign in_ready  = (state_q == OCIOSO);
    assign ocupado   = (state_q == SOMANDO);
    assign out_valid = (state_q == PRONTO);
    assign S         = s_q;
    assign C_out     = c_out_q;
`ifdef SOMADOR_SERIAL_OVF_EN
    assign overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_somador_serial.sv
// Directed bench for somador_serial: an N=8 instance for the scenarios and an N=2 instance swept exhaustively.
module tb_somador_serial;

    localparam int unsigned N = 8;
    localparam int unsigned M = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         in_valid, in_ready, c_in, out_valid, out_ready, c_out, ocupado;
    logic [N-1:0] a, b, s;
    logic         t_in_valid, t_in_ready, t_c_in, t_out_valid, t_out_ready, t_c_out, t_ocupado;
    logic [M-1:0] t_a, t_b, t_s;
`ifdef SOMADOR_SERIAL_OVF_EN
    logic         overflow, t_overflow;
`endif

    int checks = 0;
    int errors = 0;

    somador_serial #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(a), .B(b), .C_in(c_in), .out_valid(out_valid), .out_ready(out_ready),
        .S(s), .C_out(c_out),
`ifdef SOMADOR_SERIAL_OVF_EN
        .overflow(overflow),
`endif
        .ocupado(ocupado)
    );

    somador_serial #(.N(M)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(t_in_valid), .in_ready(t_in_ready),
        .A(t_a), .B(t_b), .C_in(t_c_in), .out_valid(t_out_valid), .out_ready(t_out_ready),
        .S(t_s), .C_out(t_c_out),
`ifdef SOMADOR_SERIAL_OVF_EN
        .overflow(t_overflow),
`endif
        .ocupado(t_ocupado)
    );

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if ({s, c_out, out_valid, ocupado, in_ready} !== {8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_outputs: got S=%h C_out=%b ov=%b oc=%b ir=%b, want S=00 C_out=0 ov=0 oc=0 ir=1",
                     s, c_out, out_valid, ocupado, in_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Accept one operand set, wait for the result and check latency and value; leaves the result pending.
    task automatic do_add(input logic [N-1:0] av, input logic [N-1:0] bv, input logic cv,
                          input logic [N-1:0] s_exp, input logic c_exp, input logic ovf_exp,
                          input string name);
        int lat;
        a = av; b = bv; c_in = cv; in_valid = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_in_ready: got %b want 1", name, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom); c_in = 1'($urandom);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            if (out_valid === 1'b1) break;
            @(posedge clk); #1;
            lat = k;
        end
        checks++;
        if (lat != N || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_latency: got %0d edges (out_valid=%b) want %0d", name, lat, out_valid, N);
        end
        checks++;
        if (s !== s_exp || c_out !== c_exp) begin
            errors++;
            $display("FAIL %s_sum: got S=%h C_out=%b want S=%h C_out=%b", name, s, c_out, s_exp, c_exp);
        end
`ifdef SOMADOR_SERIAL_OVF_EN
        checks++;
        if (overflow !== ovf_exp) begin
            errors++;
            $display("FAIL %s_overflow: got %b want %b", name, overflow, ovf_exp);
        end
`else
        if (ovf_exp === 1'bx) $display("unused overflow expectation");
`endif
    endtask

    task automatic take_result(input string name);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_release: got out_valid=%b in_ready=%b want 0 1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_basic();
        do_add(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, "add_0f_01");
        take_result("add_0f_01");
        do_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "add_ff_01");
        take_result("add_ff_01");
        do_add(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "add_7f_01");
        take_result("add_7f_01");
    endtask

    task automatic test_idle_out_ready();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || s !== 8'h80) begin
            errors++;
            $display("FAIL idle_out_ready: got ov=%b ir=%b S=%h want 0 1 80", out_valid, in_ready, s);
        end
    endtask

    task automatic test_backpressure();
        do_add(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, "add_ff_ff");
        in_valid = 1'b1; a = 8'h12; b = 8'h34; c_in = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            checks++;
            if (s !== 8'hFF || c_out !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b1 || ocupado !== 1'b0) begin
                errors++;
                $display("FAIL hold_%0d: got S=%h C_out=%b ir=%b ov=%b oc=%b want FF 1 0 1 0",
                         k, s, c_out, in_ready, out_valid, ocupado);
            end
        end
        in_valid = 1'b0;
        take_result("add_ff_ff");
        checks++;
        if (s !== 8'hFF || c_out !== 1'b1) begin
            errors++;
            $display("FAIL keep_after_release: got S=%h C_out=%b want FF 1", s, c_out);
        end
    endtask

    task automatic test_reset_mid_add();
        a = 8'h12; b = 8'h34; c_in = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (ocupado !== 1'b1) begin
            errors++;
            $display("FAIL busy_before_reset: got ocupado=%b want 1", ocupado);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({s, c_out, out_valid, ocupado, in_ready} !== {8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL mid_reset_outputs: got S=%h C_out=%b ov=%b oc=%b ir=%b want 00 0 0 0 1",
                     s, c_out, out_valid, ocupado, in_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_add(8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0, "add_after_reset");
        take_result("add_after_reset");
    endtask

    task automatic test_exhaustive_n2();
        int sa, sb, tot, lat;
        logic [2:0] exp_sum;
        logic exp_ovf;
        t_out_ready = 1'b1;
        for (int ai = 0; ai < 4; ai++) begin
            for (int bi = 0; bi < 4; bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    exp_sum = 3'(ai + bi + ci);
                    sa = (ai >= 2) ? ai - 4 : ai;
                    sb = (bi >= 2) ? bi - 4 : bi;
                    tot = sa + sb + ci;
                    exp_ovf = (tot > 1 || tot < -2);
                    t_a = 2'(ai); t_b = 2'(bi); t_c_in = 1'(ci); t_in_valid = 1'b1;
                    @(posedge clk); #1;
                    t_in_valid = 1'b0;
                    lat = 0;
                    for (int k = 1; k <= 10; k++) begin
                        if (t_out_valid === 1'b1) break;
                        @(posedge clk); #1;
                        lat = k;
                    end
                    checks++;
                    if (t_out_valid !== 1'b1 || lat != M || {t_c_out, t_s} !== exp_sum) begin
                        errors++;
                        $display("FAIL n2_%0d_%0d_%0d: got ov=%b lat=%0d sum=%h want ov=1 lat=%0d sum=%h",
                                 ai, bi, ci, t_out_valid, lat, {t_c_out, t_s}, M, exp_sum);
                    end
`ifdef SOMADOR_SERIAL_OVF_EN
                    checks++;
                    if (t_overflow !== exp_ovf) begin
                        errors++;
                        $display("FAIL n2_ovf_%0d_%0d_%0d: got %b want %b", ai, bi, ci, t_overflow, exp_ovf);
                    end
`else
                    if (exp_ovf === 1'bx) $display("unused overflow expectation");
`endif
                    @(posedge clk); #1;
                end
            end
        end
        t_out_ready = 1'b0;
    endtask

    initial begin
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; c_in = 1'b0;
        t_in_valid = 1'b0; t_out_ready = 1'b0; t_a = '0; t_b = '0; t_c_in = 1'b0;
        test_reset();
        test_basic();
        test_idle_out_ready();
        test_backpressure();
        test_reset_mid_add();
        test_exhaustive_n2();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
